// File: rtl/lfsr_checker_if.sv
// ---------------------------------------------------------------------------
// lfsr_checker_if
// Purpose : groups the data/control/status signals of lfsr_checker so that
//           the checker and its driver share one bundle.
// Params  : CNT_W - width of the error counters.
// Signals : in_valid      - in_data carries a sequence word this cycle
//           in_data[15:0] - word from the upstream 16-bit Fibonacci LFSR
//           clear_count   - synchronous clear of the error counters
//           locked        - checker is synchronised to the sequence
//           error         - one-cycle pulse per mismatched word while locked
//           err_count     - saturating count of mismatched words while locked
//           bit_err_count - saturating count of wrong bits while locked
//                           (present only with LFSR_CHECKER_BITCOUNT_EN)
// Modports: master drives the word stream, slave is the checker.
// ---------------------------------------------------------------------------
interface lfsr_checker_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [15:0]      in_data;
  logic             clear_count;
  logic             locked;
  logic             error;
  logic [CNT_W-1:0] err_count;
`ifdef LFSR_CHECKER_BITCOUNT_EN
  logic [CNT_W-1:0] bit_err_count;

  modport master (
    output in_valid, in_data, clear_count,
    input  locked, error, err_count, bit_err_count
  );
  modport slave (
    input  in_valid, in_data, clear_count,
    output locked, error, err_count, bit_err_count
  );
`else
  modport master (
    output in_valid, in_data, clear_count,
    input  locked, error, err_count
  );
  modport slave (
    input  in_valid, in_data, clear_count,
    output locked, error, err_count
  );
`endif
endinterface

// File: rtl/lfsr_checker.sv
// ---------------------------------------------------------------------------
// lfsr_checker
// Purpose : checks a stream of words produced by a 16-bit Fibonacci LFSR
//           (next(w) = {w[14:0], w[15]^w[13]^w[12]^w[10]}). It searches for a
//           non-zero seed, verifies LOCK_COUNT consecutive predicted words,
//           then flywheels its own prediction and flags every mismatching
//           word. LOSS_COUNT consecutive mismatches drop the lock.
// Ports   : clk   - sole clock, all state updates on its rising edge
//           reset - synchronous, active-high reset
//           bus   - lfsr_checker_if.slave (in_valid, in_data, clear_count,
//                   locked, error, err_count [, bit_err_count])
// Params  : LOCK_COUNT (1..15), LOSS_COUNT (1..15), CNT_W counter width.
// Option  : define LFSR_CHECKER_BITCOUNT_EN to add bit_err_count, the
//           saturating sum of wrong bits over all locked mismatches.
// ---------------------------------------------------------------------------
module lfsr_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic           clk,
  input  logic           reset,
  lfsr_checker_if.slave  bus
);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  localparam logic [3:0] LOCK_CNT_L = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_CNT_L = 4'(LOSS_COUNT);

  function automatic logic [15:0] lfsr_next(input logic [15:0] w);
    return {w[14:0], w[15] ^ w[13] ^ w[12] ^ w[10]};
  endfunction

  state_t           r_state, w_state_next;
  logic [15:0]      r_ref, w_ref_next;
  logic [3:0]       r_match_cnt, w_match_cnt_next;
  logic [3:0]       r_miss_cnt, w_miss_cnt_next;
  logic             r_locked, w_locked_next;
  logic             r_error, w_error_next;
  logic [CNT_W-1:0] r_err_count, w_err_count_next;

  logic [15:0] w_pred;
  logic        w_match;
  logic        w_locked_miss;

  // The word we expect next; in VERIFY it is compared against, in LOCKED
  // it also becomes the new reference whatever arrives (flywheel).
  assign w_pred        = lfsr_next(r_ref);
  assign w_match       = (bus.in_data == w_pred);
  assign w_locked_miss = bus.in_valid && (r_state == LOCKED) && !w_match;

  always_comb begin
    w_state_next     = r_state;
    w_ref_next       = r_ref;
    w_match_cnt_next = r_match_cnt;
    w_miss_cnt_next  = r_miss_cnt;
    w_locked_next    = r_locked;
    w_error_next     = 1'b0;
    w_err_count_next = r_err_count;

    // Clear wins over a simultaneous locked mismatch; error still pulses.
    if (bus.clear_count) begin
      w_err_count_next = '0;
    end else if (w_locked_miss && (r_err_count != '1)) begin
      w_err_count_next = r_err_count + 1'b1;
    end

    if (bus.in_valid) begin
      unique case (r_state)
        SEARCH: begin
          if (bus.in_data != 16'h0000) begin
            w_ref_next       = bus.in_data;
            w_match_cnt_next = '0;
            w_state_next     = VERIFY;
          end
        end
        VERIFY: begin
          if (w_match) begin
            w_ref_next       = bus.in_data;
            w_match_cnt_next = r_match_cnt + 4'd1;
            if ((r_match_cnt + 4'd1) == LOCK_CNT_L) begin
              w_state_next    = LOCKED;
              w_locked_next   = 1'b1;
              w_miss_cnt_next = '0;
            end
          end else if (bus.in_data == 16'h0000) begin
            // An all-zero word can never seed an LFSR run.
            w_match_cnt_next = '0;
            w_state_next     = SEARCH;
          end else begin
            w_ref_next       = bus.in_data;
            w_match_cnt_next = '0;
          end
        end
        LOCKED: begin
          w_ref_next = w_pred;
          if (w_match) begin
            w_miss_cnt_next = '0;
          end else begin
            w_error_next    = 1'b1;
            w_miss_cnt_next = r_miss_cnt + 4'd1;
            if ((r_miss_cnt + 4'd1) == LOSS_CNT_L) begin
              w_miss_cnt_next = '0;
              w_locked_next   = 1'b0;
              w_state_next    = SEARCH;
            end
          end
        end
        default: begin
          w_state_next  = SEARCH;
          w_locked_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= SEARCH;
      r_ref       <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_locked    <= 1'b0;
      r_error     <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_next;
      r_ref       <= w_ref_next;
      r_match_cnt <= w_match_cnt_next;
      r_miss_cnt  <= w_miss_cnt_next;
      r_locked    <= w_locked_next;
      r_error     <= w_error_next;
      r_err_count <= w_err_count_next;
    end
  end

  assign bus.locked    = r_locked;
  assign bus.error     = r_error;
  assign bus.err_count = r_err_count;

`ifdef LFSR_CHECKER_BITCOUNT_EN
  // Sum is kept wide enough that any overflow past CNT_W bits is visible
  // in the upper bits, which then selects saturation.
  localparam int SUM_W = CNT_W + 6;

  logic [15:0]      w_diff;
  logic [4:0]       w_popcnt;
  logic [SUM_W-1:0] w_bit_sum;
  logic [CNT_W-1:0] r_bit_err_count, w_bit_err_count_next;

  assign w_diff    = bus.in_data ^ w_pred;
  assign w_bit_sum = SUM_W'(r_bit_err_count) + SUM_W'(w_popcnt);

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < 16; i++) begin
      w_popcnt = w_popcnt + 5'(w_diff[i]);
    end
  end

  always_comb begin
    w_bit_err_count_next = r_bit_err_count;
    if (bus.clear_count) begin
      w_bit_err_count_next = '0;
    end else if (w_locked_miss) begin
      if (w_bit_sum[SUM_W-1:CNT_W] != '0) begin
        w_bit_err_count_next = '1;
      end else begin
        w_bit_err_count_next = w_bit_sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_err_count <= '0;
    end else begin
      r_bit_err_count <= w_bit_err_count_next;
    end
  end

  assign bus.bit_err_count = r_bit_err_count;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_checker
// Two checkers (CNT_W=16 and CNT_W=4) receive the same word stream. A
// behavioural model tracks the expected outputs of both; a compare process
// checks every cycle, and directed scenarios add literal checks.
// ---------------------------------------------------------------------------
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        clear_count = 1'b0;

  always #5 clk = ~clk;

  lfsr_checker_if #(.CNT_W(16)) if16 ();
  lfsr_checker_if #(.CNT_W(4))  if4 ();

  assign if16.in_valid    = in_valid;
  assign if16.in_data     = in_data;
  assign if16.clear_count = clear_count;
  assign if4.in_valid     = in_valid;
  assign if4.in_data      = in_data;
  assign if4.clear_count  = clear_count;

  lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (if16.slave)
  );

  lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Sequence rule: shift left, feed back parity of taps 15,13,12,10.
  function automatic logic [15:0] nxt(input logic [15:0] w);
    return {w[14:0], ^(w & 16'hB400)};
  endfunction

  function automatic int sat_add(input int a, input int b, input int maxv);
    return (a + b > maxv) ? maxv : a + b;
  endfunction

  // ---------------- behavioural model ----------------
  localparam int HUNT = 0, TRAIN = 1, TRACK = 2;
  int          m_mode = HUNT;
  logic [15:0] m_last = 16'h0000;
  int          m_run = 0;
  int          m_miss = 0;
  logic        exp_locked = 1'b0;
  logic        exp_error = 1'b0;
  int          exp_err16 = 0, exp_err4 = 0, exp_bit16 = 0, exp_bit4 = 0;

  always @(posedge clk) begin
    logic [15:0] pred;
    int          pc;
    if (reset) begin
      m_mode = HUNT; m_last = 16'h0000; m_run = 0; m_miss = 0;
      exp_locked = 1'b0; exp_error = 1'b0;
      exp_err16 = 0; exp_err4 = 0; exp_bit16 = 0; exp_bit4 = 0;
    end else begin
      exp_error = 1'b0;
      if (clear_count) begin
        exp_err16 = 0; exp_err4 = 0; exp_bit16 = 0; exp_bit4 = 0;
      end
      if (in_valid) begin
        pred = nxt(m_last);
        if (m_mode == HUNT) begin
          if (in_data != 16'h0000) begin
            m_last = in_data; m_run = 0; m_mode = TRAIN;
          end
        end else if (m_mode == TRAIN) begin
          if (in_data == pred) begin
            m_last = in_data;
            m_run++;
            if (m_run == 4) begin
              m_mode = TRACK; exp_locked = 1'b1; m_miss = 0;
            end
          end else if (in_data == 16'h0000) begin
            m_mode = HUNT; m_run = 0;
          end else begin
            m_last = in_data; m_run = 0;
          end
        end else begin
          m_last = pred;
          if (in_data == pred) begin
            m_miss = 0;
          end else begin
            exp_error = 1'b1;
            pc = $countones(in_data ^ pred);
            if (!clear_count) begin
              exp_err16 = sat_add(exp_err16, 1, 65535);
              exp_err4  = sat_add(exp_err4, 1, 15);
              exp_bit16 = sat_add(exp_bit16, pc, 65535);
              exp_bit4  = sat_add(exp_bit4, pc, 15);
            end
            m_miss++;
            if (m_miss == 3) begin
              m_mode = HUNT; m_miss = 0; exp_locked = 1'b0;
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("locked16", 32'(if16.locked), 32'(exp_locked));
      chk("error16", 32'(if16.error), 32'(exp_error));
      chk("err_count16", 32'(if16.err_count), 32'(exp_err16));
      chk("locked4", 32'(if4.locked), 32'(exp_locked));
      chk("error4", 32'(if4.error), 32'(exp_error));
      chk("err_count4", 32'(if4.err_count), 32'(exp_err4));
`ifdef LFSR_CHECKER_BITCOUNT_EN
      chk("bit_err16", 32'(if16.bit_err_count), 32'(exp_bit16));
      chk("bit_err4", 32'(if4.bit_err_count), 32'(exp_bit4));
`endif
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0] g;

  task automatic beat(input logic v, input logic [15:0] d, input logic c);
    @(negedge clk);
    in_valid = v; in_data = d; clear_count = c;
    $display("beat t=%0t valid=%0b data=%h clear=%0b", $time, v, d, c);
  endtask

  task automatic send_good(input logic c);
    g = nxt(g);
    beat(1'b1, g, c);
  endtask

  task automatic send_bad(input logic [15:0] mask, input logic c);
    g = nxt(g);
    beat(1'b1, g ^ mask, c);
  endtask

  task automatic settle;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; clear_count = 1'b0;
    $display("reset pulse t=%0t", $time);
    settle();
    chk("rst_locked", 32'(if16.locked), 32'd0);
    chk("rst_err_count", 32'(if16.err_count), 32'd0);
    chk("rst_error", 32'(if16.error), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int r;
    // Reset and idle state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    settle();
    chk("init_locked", 32'(if16.locked), 32'd0);
    chk("init_err", 32'(if16.err_count), 32'd0);

    // Zeros in SEARCH: nothing happens
    repeat (6) beat(1'b1, 16'h0000, 1'b0);
    settle();
    chk("zeros_locked", 32'(if16.locked), 32'd0);

    // Lock on 0xACE1 run: not yet after 4 words, locked after the 5th
    g = 16'hACE1;
    beat(1'b1, g, 1'b0);
    repeat (3) send_good(1'b0);
    settle();
    chk("lock_4th", 32'(if16.locked), 32'd0);
    send_good(1'b0);
    settle();
    chk("lock_5th", 32'(if16.locked), 32'd1);
    chk("lock_word2", 32'(nxt(16'hACE1) == 16'h59C3), 32'(in_data != 16'h0000));

    // Single corrupted word
    send_bad(16'h0001, 1'b0);
    settle();
    chk("corrupt_error", 32'(if16.error), 32'd1);
    chk("corrupt_cnt", 32'(if16.err_count), 32'd1);
`ifdef LFSR_CHECKER_BITCOUNT_EN
    chk("corrupt_bits", 32'(if16.bit_err_count), 32'd1);
`endif
    repeat (3) send_good(1'b0);
    settle();
    chk("resume_locked", 32'(if16.locked), 32'd1);
    chk("resume_error", 32'(if16.error), 32'd0);

    // Three consecutive wrong words drop lock
    repeat (2) send_bad(16'h00F0, 1'b0);
    settle();
    chk("loss_2nd", 32'(if16.locked), 32'd1);
    send_bad(16'h00F0, 1'b0);
    settle();
    chk("loss_3rd", 32'(if16.locked), 32'd0);
    chk("loss_cnt", 32'(if16.err_count), 32'd4);

    // Relock on a fresh run
    g = 16'h1234;
    beat(1'b1, g, 1'b0);
    repeat (4) send_good(1'b0);
    settle();
    chk("relock", 32'(if16.locked), 32'd1);

    // 20 mismatches interleaved with matches: 4-bit counter saturates
    repeat (20) begin
      send_bad(16'h8000, 1'b0);
      send_good(1'b0);
    end
    settle();
    chk("sat_cnt4", 32'(if4.err_count), 32'd15);
    chk("sat_cnt16", 32'(if16.err_count), 32'd24);
    chk("sat_locked", 32'(if4.locked), 32'd1);

    // Clear together with a mismatch: clear wins, error still pulses
    send_bad(16'h0001, 1'b1);
    settle();
    chk("clr_cnt4", 32'(if4.err_count), 32'd0);
    chk("clr_cnt16", 32'(if16.err_count), 32'd0);
    chk("clr_error", 32'(if4.error), 32'd1);
    send_good(1'b0);

    // Reach err_count=7 while locked, then reset
    repeat (7) begin
      send_bad(16'h0002, 1'b0);
      send_good(1'b0);
    end
    settle();
    chk("seven_cnt", 32'(if16.err_count), 32'd7);
    pulse_reset();

    // Gaps mid-VERIFY do not disturb match progress
    g = 16'hBEEF;
    beat(1'b1, g, 1'b0);
    send_good(1'b0);
    repeat (3) beat(1'b0, 16'hFFFF, 1'b0);
    send_good(1'b0);
    beat(1'b0, 16'h0000, 1'b0);
    send_good(1'b0);
    send_good(1'b0);
    settle();
    chk("gap_lock", 32'(if16.locked), 32'd1);

    // Randomized traffic, checked every cycle by the model
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 60)       send_good($urandom_range(0, 24) == 0);
      else if (r < 72)  send_bad(16'($urandom_range(1, 65535)), $urandom_range(0, 9) == 0);
      else if (r < 77)  beat(1'b1, 16'h0000, 1'b0);
      else if (r < 85)  beat(1'b0, 16'($urandom), $urandom_range(0, 9) == 0);
      else if (r < 91)  begin g = 16'($urandom_range(1, 65535)); beat(1'b1, g, 1'b0); end
      else if (r < 98)  beat(1'b1, 16'($urandom), 1'b0);
      else              pulse_reset();
    end

    beat(1'b0, 16'h0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
